// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the MEM-stage access controller.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef logic [2:0] mem_state_t;

   localparam mem_state_t ST_IDLE   = 3'd0;
   localparam mem_state_t ST_LOAD   = 3'd1;
   localparam mem_state_t ST_STORE  = 3'd2;
   localparam mem_state_t ST_RMW_RD = 3'd3;
   localparam mem_state_t ST_RMW_WR = 3'd4;
   localparam mem_state_t ST_RESP   = 3'd5;

   localparam int DEFAULT_BASE_ADDR   = 1024;
   localparam int DEFAULT_DEPTH_WORDS = 64;

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module mem_lane_unit
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word[7:0];
      case (lane)
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         2'd3:    byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v = lane[1] ? word[31:16] : word[15:0];

      load_data = word;
      case (size)
         SZ_BYTE: load_data = is_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
         SZ_HALF: load_data = is_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
         default: load_data = word;
      endcase

      store_word = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               2'd3:    store_word[31:24] = wdata[7:0];
               default: store_word[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: one request at a time, sub-word access via lane unit.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | ready for a request, checks size/alignment/range
// LOAD      | memory read, lane result captured into response
// STORE     | full-word memory write
// RMW_RD    | read old word for a sub-word store
// RMW_WR    | write merged word
// RESP      | one-cycle response pulse
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int WORD_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32,
   parameter int BASE_ADDR    = DEFAULT_BASE_ADDR,
   parameter int DEPTH_WORDS  = DEFAULT_DEPTH_WORDS
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_unsigned,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]    req_wdata,
   output logic                    resp_valid,
   output logic                    resp_err,
   output logic [WORD_SIZE-1:0]    resp_rdata,
   output logic [ADDRESS_SIZE-1:0] Address,
   output logic [WORD_SIZE-1:0]    WriteData,
   output logic                    MemRead,
   output logic                    MemWrite,
   input  logic [WORD_SIZE-1:0]    ReadData
);

   localparam logic [ADDRESS_SIZE:0] ADDR_LO = (ADDRESS_SIZE+1)'(BASE_ADDR);
   localparam logic [ADDRESS_SIZE:0] ADDR_HI = (ADDRESS_SIZE+1)'(BASE_ADDR)
                                             + (ADDRESS_SIZE+1)'(4 * DEPTH_WORDS);

   mem_state_t              state;
   logic                    write_q;
   logic [1:0]              size_q;
   logic                    unsigned_q;
   logic [ADDRESS_SIZE-1:0] addr_q;
   logic [WORD_SIZE-1:0]    wdata_q;
   logic [WORD_SIZE-1:0]    old_q;
   logic                    err_q;
   logic [WORD_SIZE-1:0]    rdata_q;

   logic                    req_bad;
   logic                    misaligned;
   logic                    out_of_range;
   logic [31:0]             lane_word;
   logic [31:0]             load_data;
   logic [31:0]             store_word;

   always_comb begin
      misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
      out_of_range = ({1'b0, req_addr} < ADDR_LO) || ({1'b0, req_addr} >= ADDR_HI);
      req_bad      = (req_size == 2'd3) || misaligned || out_of_range;
   end

   // The merge works on the captured old word; loads extract straight from memory.
   assign lane_word = (state == ST_RMW_WR) ? old_q : ReadData;

   mem_lane_unit u_lane (
      .word        (lane_word),
      .lane        (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         write_q    <= 1'b0;
         size_q     <= SZ_BYTE;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  write_q    <= req_write;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  if (req_bad) begin
                     err_q <= 1'b1;
                     state <= ST_RESP;
                  end else if (!req_write) begin
                     state <= ST_LOAD;
                  end else if (req_size == SZ_WORD) begin
                     state <= ST_STORE;
                  end else begin
                     state <= ST_RMW_RD;
                  end
               end
            end
            ST_LOAD: begin
               rdata_q <= load_data;
               state   <= ST_RESP;
            end
            ST_STORE:  state <= ST_RESP;
            ST_RMW_RD: begin
               old_q <= ReadData;
               state <= ST_RMW_WR;
            end
            ST_RMW_WR: state <= ST_RESP;
            ST_RESP: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
               state   <= ST_IDLE;
            end
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      case (state)
         ST_LOAD, ST_RMW_RD: begin
            MemRead = 1'b1;
            Address = {addr_q[ADDRESS_SIZE-1:2], 2'b00};
         end
         ST_STORE: begin
            MemWrite  = 1'b1;
            Address   = {addr_q[ADDRESS_SIZE-1:2], 2'b00};
            WriteData = wdata_q;
         end
         ST_RMW_WR: begin
            MemWrite  = 1'b1;
            Address   = {addr_q[ADDRESS_SIZE-1:2], 2'b00};
            WriteData = store_word;
         end
         default: ;
      endcase
   end

   assign req_ready  = (state == ST_IDLE) && rst_n;
   assign resp_valid = (state == ST_RESP);
   assign resp_err   = err_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a word-only memory model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata, Address, WriteData, ReadData;
   logic        MemRead, MemWrite;

   logic [31:0] mem [0:63];
   logic [31:0] moff;

   int n_cmp = 0;
   int n_bad = 0;

   int          t_lat, t_rd, t_wr, t_rd_at, t_wr_at, t_both;
   logic        t_err;
   logic [31:0] t_rdata;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .Address(Address), .WriteData(WriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
   );

   assign moff     = Address - 32'd1024;
   assign ReadData = MemRead ? mem[moff[7:2]] : 32'h0;

   always @(posedge clk) if (MemWrite) mem[moff[7:2]] <= WriteData;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      t_lat = 99; t_err = 1'b0; t_rdata = 32'hBAD0_BAD0;
      t_rd = 0; t_wr = 0; t_rd_at = 0; t_wr_at = 0; t_both = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (MemRead)  begin t_rd++; t_rd_at = c; end
         if (MemWrite) begin t_wr++; t_wr_at = c; end
         if (MemRead && MemWrite) t_both++;
         if (resp_valid) begin
            t_lat = c; t_err = resp_err; t_rdata = resp_rdata;
            break;
         end
      end
   endtask

   task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input int e_lat, input logic e_err, input logic [31:0] e_rdata,
                      input int e_rd, input int e_wr);
      do_req(w, sz, u, a, d);
      check({tag, "_lat"},   t_lat, e_lat);
      check({tag, "_err"},   {31'd0, t_err}, {31'd0, e_err});
      check({tag, "_rdata"}, t_rdata, e_rdata);
      check({tag, "_nrd"},   t_rd, e_rd);
      check({tag, "_nwr"},   t_wr, e_wr);
      check({tag, "_both"},  t_both, 0);
   endtask

   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];
   logic [31:0] b2b_got  [3];
   int          n_acc, n_resp, ready_viol, rst_activity;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      #2;
      check("rst_ready", {31'd0, req_ready}, 0);
      check("rst_memctl", {30'd0, MemRead, MemWrite}, 0);
      check("rst_addr", Address, 0);
      check("rst_wdata", WriteData, 0);
      check("rst_resp", {30'd0, resp_valid, resp_err}, 0);
      check("rst_rdata", resp_rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'd0, req_ready}, 1);

      // word store / load
      txn("st_w",  1, 2'd2, 0, 32'd1024, 32'hDEADBEEF, 2, 0, 32'h0, 0, 1);
      txn("ld_w",  0, 2'd2, 0, 32'd1024, 32'h0,        2, 0, 32'hDEADBEEF, 1, 0);

      // byte read-modify-write
      txn("st_w2", 1, 2'd2, 0, 32'd1024, 32'h11223344, 2, 0, 32'h0, 0, 1);
      txn("st_b",  1, 2'd0, 0, 32'd1026, 32'h000000AA, 3, 0, 32'h0, 1, 1);
      check("st_b_rd_at", t_rd_at, 1);
      check("st_b_wr_at", t_wr_at, 2);
      txn("ld_w2", 0, 2'd2, 0, 32'd1024, 32'h0,        2, 0, 32'h11AA3344, 1, 0);

      // extension
      txn("st_w3", 1, 2'd2, 0, 32'd1032, 32'h8000F0F0, 2, 0, 32'h0, 0, 1);
      txn("ld_bs", 0, 2'd0, 0, 32'd1033, 32'h0,        2, 0, 32'hFFFFFFF0, 1, 0);
      txn("ld_hu", 0, 2'd1, 1, 32'd1034, 32'h0,        2, 0, 32'h00008000, 1, 0);
      txn("ld_hs", 0, 2'd1, 0, 32'd1034, 32'h0,        2, 0, 32'hFFFF8000, 1, 0);
      txn("ld_bu", 0, 2'd0, 1, 32'd1035, 32'h0,        2, 0, 32'h00000080, 1, 0);
      txn("st_h",  1, 2'd1, 0, 32'd1034, 32'h1234CAFE, 3, 0, 32'h0, 1, 1);
      txn("ld_w3", 0, 2'd2, 0, 32'd1032, 32'h0,        2, 0, 32'hCAFEF0F0, 1, 0);

      // errors and range boundaries
      txn("e_wmis", 0, 2'd2, 0, 32'd1026, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("e_hmis", 0, 2'd1, 0, 32'd1025, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("e_sz3",  0, 2'd3, 0, 32'd1024, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("e_low",  0, 2'd2, 0, 32'd1020, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("e_high", 0, 2'd2, 0, 32'd1280, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("e_stb",  1, 2'd0, 0, 32'd1280, 32'h0, 1, 1, 32'h0, 0, 0);
      txn("st_top", 1, 2'd2, 0, 32'd1276, 32'h0BADF00D, 2, 0, 32'h0, 0, 1);
      txn("ld_top", 0, 2'd2, 0, 32'd1276, 32'h0,        2, 0, 32'h0BADF00D, 1, 0);

      // back-to-back loads with req_valid held
      b2b_addr[0] = 32'd1024; b2b_exp[0] = 32'h11AA3344;
      b2b_addr[1] = 32'd1032; b2b_exp[1] = 32'hCAFEF0F0;
      b2b_addr[2] = 32'd1276; b2b_exp[2] = 32'h0BADF00D;
      n_acc = 0; n_resp = 0; ready_viol = 0;
      req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready && (MemRead || resp_valid)) ready_viol++;
         if (resp_valid) begin
            if (n_resp < 3) b2b_got[n_resp] = resp_rdata;
            n_resp++;
         end
         if (req_ready) begin
            if (n_acc < 3) begin
               req_addr = b2b_addr[n_acc];
               req_valid = 1'b1;
               n_acc++;
            end else begin
               req_valid = 1'b0;
            end
         end
         if (n_resp >= 3 && !req_valid) break;
      end
      req_valid = 1'b0;
      check("b2b_nresp", n_resp, 3);
      check("b2b_ready", ready_viol, 0);
      for (int i = 0; i < 3; i++)
         check($sformatf("b2b_rdata%0d", i), b2b_got[i], b2b_exp[i]);

      // reset during RMW_RD
      txn("st_pre", 1, 2'd2, 0, 32'd1028, 32'h55667788, 2, 0, 32'h0, 0, 1);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'd1029; req_wdata = 32'h000000EE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw_rd_phase", {31'd0, MemRead}, 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ctl", {28'd0, MemRead, MemWrite, req_ready, resp_valid}, 0);
      check("arst_addr", Address, 0);
      rst_activity = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (MemWrite || resp_valid || MemRead) rst_activity++;
         if (c == 2) rst_n = 1'b1;
      end
      check("arst_quiet", rst_activity, 0);
      txn("ld_keep", 0, 2'd2, 0, 32'd1028, 32'h0, 2, 0, 32'h55667788, 1, 0);
      txn("st_b2",   1, 2'd0, 0, 32'd1029, 32'h000000EE, 3, 0, 32'h0, 1, 1);
      txn("ld_post", 0, 2'd2, 0, 32'd1028, 32'h0, 2, 0, 32'h5566EE88, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
